// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM pipeline stage and a gnt/rvalid memory port.
// Handles B/H/W sizing, lane replication, byte enables, load extension and a request timeout.
module mem_access_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       AddrModeM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             StallM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             ReadValidM,
  output logic             MisalignM,
  output logic             BusErrM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] M_B = 3'd0, M_H = 3'd1, M_W = 3'd2, M_BU = 3'd4, M_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef struct packed {
    logic       st;
    logic [2:0] mode;
    logic [1:0] off;
  } acc_t;

  state_t          state_q, state_d;
  acc_t            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q;
  logic            mem_req_q, mem_we_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, rdata_q;
  logic [3:0]      mem_be_q;

  logic [3:0]       be_d;
  logic [WIDTH-1:0] wdata_d, ext_d;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic             req_any, legal, capture, rd_load, tmo, stall_c, mis_c, last;

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    req_any = MemReadM | MemWriteM;
    acc_d   = {MemWriteM, AddrModeM, ALUResultM[1:0]};
    case (AddrModeM)
      M_B:     legal = req_any;
      M_H:     legal = req_any & ~ALUResultM[0];
      M_W:     legal = req_any & (ALUResultM[1:0] == 2'b00);
      M_BU:    legal = MemReadM & ~MemWriteM;
      M_HU:    legal = MemReadM & ~MemWriteM & ~ALUResultM[0];
      default: legal = 1'b0;
    endcase
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    if (MemWriteM) begin
      case (AddrModeM)
        M_B: begin
          be_d    = 4'b0001 << ALUResultM[1:0];
          wdata_d = {(WIDTH/8){WriteDataM[7:0]}};
        end
        M_H: begin
          be_d    = 4'b0011 << ALUResultM[1:0];
          wdata_d = {(WIDTH/16){WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction uses the offset and mode captured at request time.
  always_comb begin
    rbyte = mem_rdata[{acc_q.off, 3'b000} +: 8];
    rhalf = mem_rdata[{acc_q.off[1], 4'b0000} +: 16];
    case (acc_q.mode)
      M_B:     ext_d = {{(WIDTH-8){rbyte[7]}}, rbyte};
      M_BU:    ext_d = {{(WIDTH-8){1'b0}}, rbyte};
      M_H:     ext_d = {{(WIDTH-16){rhalf[15]}}, rhalf};
      M_HU:    ext_d = {{(WIDTH-16){1'b0}}, rhalf};
      default: ext_d = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    capture = 1'b0;
    rd_load = 1'b0;
    tmo     = 1'b0;
    last    = (cnt_q == CW'(TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (legal) begin
          stall_c = 1'b1;
          capture = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end else if (req_any) begin
          mis_c = 1'b1;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // A load granted on the final budget cycle could not finish in time.
        if (mem_gnt && acc_q.st) state_d = DONE;
        else if (last)           tmo     = 1'b1;
        else if (mem_gnt)        state_d = WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (mem_rvalid) begin
          rd_load = 1'b1;
          state_d = DONE;
        end else if (last) begin
          tmo = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        acc_q       <= acc_d;
        err_q       <= 1'b0;
        mem_req_q   <= 1'b1;
        mem_we_q    <= MemWriteM;
        mem_addr_q  <= {ALUResultM[WIDTH-1:2], 2'b00};
        mem_wdata_q <= wdata_d;
        mem_be_q    <= be_d;
      end else if (state_q == REQ && state_d != REQ) begin
        mem_req_q <= 1'b0;
      end
      if (rd_load) rdata_q <= ext_d;
      if (tmo) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Combinational pulses are gated by reset so they drop the instant rst_n falls.
  assign StallM     = stall_c & rst_n;
  assign MisalignM  = mis_c & rst_n;
  assign ReadValidM = (state_q == DONE) & ~acc_q.st & ~err_q;
  assign BusErrM    = (state_q == DONE) & err_q;
  assign ReadDataM  = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule
